// File: rtl/tx_pkg.sv
// Shared definitions for the redundant UDP video transmit scheduler.
package tx_pkg;

    localparam int SEG_NUM_MAX_DEF = 150;
    localparam int GAP_CYCLES_DEF  = 12;
    localparam int LEN_W_DEF       = 13;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_PAYLOAD,
        ST_WAIT_DONE,
        ST_GAP,
        ST_DONE
    } tx_state_e;

    // A frame is refused when any count is zero or the segment count exceeds the buffer pool.
    function automatic logic cfg_bad(input logic [15:0] num_seg,
                                     input logic [7:0]  redundancy,
                                     input logic        len_zero,
                                     input logic [15:0] num_seg_max);
        return (num_seg == 16'd0) || (redundancy == 8'd0) || len_zero || (num_seg > num_seg_max);
    endfunction

endpackage

// File: rtl/tx_seg_round_counter.sv
// Nested segment/round counter: segments 0..N-1 inside rounds 1..R, with last-packet flag.
module tx_seg_round_counter #(
    parameter int SEG_W   = 16,
    parameter int ROUND_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               advance_i,
    input  logic [SEG_W-1:0]   num_segments_i,
    input  logic [ROUND_W-1:0] redundancy_i,
    output logic [SEG_W-1:0]   seg_o,
    output logic [ROUND_W-1:0] round_o,
    output logic               last_o
);

    logic [SEG_W-1:0]   seg_q;
    logic [ROUND_W-1:0] round_q;
    logic               seg_wrap;
    logic [ROUND_W:0]   round_inc;

    // Round increment is one bit wider so a redundancy of all-ones never wraps to zero.
    assign seg_wrap  = (seg_q == num_segments_i - SEG_W'(1));
    assign round_inc = {1'b0, round_q} + (ROUND_W + 1)'(1);
    assign last_o    = seg_wrap && (round_inc > {1'b0, redundancy_i});
    assign seg_o     = seg_q;
    assign round_o   = round_q;

    // Segment steps every advance; round steps when the segment index wraps.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            seg_q   <= '0;
            round_q <= ROUND_W'(1);
        end else if (clear_i) begin
            seg_q   <= '0;
            round_q <= ROUND_W'(1);
        end else if (advance_i) begin
            if (seg_wrap) begin
                seg_q   <= '0;
                round_q <= round_inc[ROUND_W-1:0];
            end else begin
                seg_q   <= seg_q + SEG_W'(1);
            end
        end
    end

endmodule

// File: rtl/tx_segment_scheduler.sv
// Per-frame scheduler: R rounds of N segment packets, packet handshake with the Ethernet framer.
module tx_segment_scheduler
    import tx_pkg::*;
#(
    parameter int SEGMENT_NUMBER_MAX = SEG_NUM_MAX_DEF,
    parameter int GAP_CYCLES         = GAP_CYCLES_DEF,
    parameter int LEN_W              = LEN_W_DEF
) (
    input  logic             clk125MHz,
    input  logic             rst,
    input  logic             frame_start,
    input  logic [15:0]      cfg_num_segments,
    input  logic [7:0]       cfg_redundancy,
    input  logic [LEN_W-1:0] cfg_payload_len,
    output logic             pkt_req,
    input  logic             pkt_ack,
    input  logic             payload_rd,
    input  logic             pkt_done,
    output logic [7:0]       txid,
    output logic [15:0]      segment_num,
    output logic [LEN_W-1:0] count_for_bram,
    output logic             count_for_bram_en,
    output logic [LEN_W-1:0] count_for_bram_b,
    output logic             data_user,
    output logic             busy,
    output logic             frame_done,
    output logic             cfg_err,
    output logic             frame_overrun
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    tx_state_e        state_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] len_q;
    logic [GAP_W-1:0] gap_q;
    logic [15:0]      num_seg_q;
    logic [7:0]       red_q;
    logic             cfg_err_q;
    logic             overrun_q;

    logic             cfg_rejected;
    logic             start_ok;
    logic             gap_end;
    logic             last_pkt;
    logic             seg_clear;
    logic             seg_advance;
    logic [15:0]      seg_w;
    logic [7:0]       round_w;

    assign cfg_rejected = cfg_bad(cfg_num_segments, cfg_redundancy,
                                  (cfg_payload_len == '0), 16'(SEGMENT_NUMBER_MAX));
    assign start_ok     = (state_q == ST_IDLE) && frame_start && !cfg_rejected;
    assign gap_end      = (state_q == ST_GAP) && (gap_q == GAP_LAST);
    assign seg_clear    = start_ok || (gap_end && last_pkt);
    assign seg_advance  = gap_end && !last_pkt;

    tx_seg_round_counter #(
        .SEG_W   (16),
        .ROUND_W (8)
    ) u_seg_round (
        .clk_i          (clk125MHz),
        .rst_i          (rst),
        .clear_i        (seg_clear),
        .advance_i      (seg_advance),
        .num_segments_i (num_seg_q),
        .redundancy_i   (red_q),
        .seg_o          (seg_w),
        .round_o        (round_w),
        .last_o         (last_pkt)
    );

    // Packet sequencing FSM; byte counter, gap timer and status pulses live alongside it.
    always_ff @(posedge clk125MHz or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            gap_q     <= '0;
            num_seg_q <= '0;
            red_q     <= '0;
            cfg_err_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cfg_err_q <= 1'b0;
            overrun_q <= frame_start && (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (frame_start) begin
                        if (cfg_rejected) begin
                            cfg_err_q <= 1'b1;
                        end else begin
                            num_seg_q <= cfg_num_segments;
                            red_q     <= cfg_redundancy;
                            len_q     <= cfg_payload_len;
                            state_q   <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (pkt_ack) begin
                        cnt_q   <= '0;
                        state_q <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (payload_rd) begin
                        if (cnt_q == len_q - LEN_W'(1)) begin
                            // A pkt_done arriving with the final byte skips the wait state.
                            cnt_q   <= '0;
                            gap_q   <= '0;
                            state_q <= pkt_done ? ST_GAP : ST_WAIT_DONE;
                        end else begin
                            cnt_q <= cnt_q + LEN_W'(1);
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    if (pkt_done) begin
                        gap_q   <= '0;
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_q <= last_pkt ? ST_DONE : ST_REQ;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // data_user is a pure state decode, so it falls exactly once per packet without glitches.
    assign pkt_req           = (state_q == ST_REQ);
    assign data_user         = (state_q == ST_PAYLOAD);
    assign busy              = (state_q != ST_IDLE);
    assign frame_done        = (state_q == ST_DONE);
    assign count_for_bram_en = data_user && payload_rd;
    assign count_for_bram    = cnt_q;
    assign count_for_bram_b  = cnt_q;
    assign txid              = round_w;
    assign segment_num       = seg_w;
    assign cfg_err           = cfg_err_q;
    assign frame_overrun     = overrun_q;

endmodule

// File: tb/tb_tx_segment_scheduler.sv
// Directed bench for tx_segment_scheduler with a simple framer model and passive monitor.
module tb_tx_segment_scheduler;

    localparam int LW = 13;

    logic          clk125MHz = 1'b0;
    logic          rst = 1'b1;
    logic          frame_start = 1'b0;
    logic [15:0]   cfg_num_segments = '0;
    logic [7:0]    cfg_redundancy = '0;
    logic [LW-1:0] cfg_payload_len = '0;
    logic          pkt_ack = 1'b0;
    logic          payload_rd = 1'b0;
    logic          pkt_done = 1'b0;
    logic          pkt_req;
    logic [7:0]    txid;
    logic [15:0]   segment_num;
    logic [LW-1:0] count_for_bram;
    logic          count_for_bram_en;
    logic [LW-1:0] count_for_bram_b;
    logic          data_user;
    logic          busy;
    logic          frame_done;
    logic          cfg_err;
    logic          frame_overrun;

    int n_checks = 0;
    int n_errors = 0;

    tx_segment_scheduler #(
        .SEGMENT_NUMBER_MAX (150),
        .GAP_CYCLES         (12),
        .LEN_W              (LW)
    ) dut (
        .clk125MHz         (clk125MHz),
        .rst               (rst),
        .frame_start       (frame_start),
        .cfg_num_segments  (cfg_num_segments),
        .cfg_redundancy    (cfg_redundancy),
        .cfg_payload_len   (cfg_payload_len),
        .pkt_req           (pkt_req),
        .pkt_ack           (pkt_ack),
        .payload_rd        (payload_rd),
        .pkt_done          (pkt_done),
        .txid              (txid),
        .segment_num       (segment_num),
        .count_for_bram    (count_for_bram),
        .count_for_bram_en (count_for_bram_en),
        .count_for_bram_b  (count_for_bram_b),
        .data_user         (data_user),
        .busy              (busy),
        .frame_done        (frame_done),
        .cfg_err           (cfg_err),
        .frame_overrun     (frame_overrun)
    );

    always #4 clk125MHz = ~clk125MHz;

    // ---------------- passive monitor (sampled on the falling edge) ----------------
    int cyc = 0;
    always @(posedge clk125MHz) cyc <= cyc + 1;

    int log_txid[$];
    int log_seg[$];
    int log_gap[$];
    int strobes_tot = 0, addr_err_tot = 0, du_falls_tot = 0, fdone_tot = 0;
    int cfgerr_tot = 0, ovr_tot = 0, txid0_tot = 0, req_tot = 0;
    int pkt_strobes = 0, last_done = 0;
    bit done_vld = 1'b0, prev_du = 1'b0, prev_req = 1'b0;

    always @(negedge clk125MHz) begin
        if (rst) begin
            prev_du  <= 1'b0;
            prev_req <= 1'b0;
            done_vld <= 1'b0;
        end else begin
            if (pkt_req && !prev_req) begin
                log_txid.push_back(int'(txid));
                log_seg.push_back(int'(segment_num));
                log_gap.push_back(done_vld ? (cyc - last_done - 1) : 9999);
                req_tot <= req_tot + 1;
            end
            if (pkt_req && pkt_ack) pkt_strobes <= 0;
            if (data_user && (int'(count_for_bram) != pkt_strobes || int'(count_for_bram_b) != pkt_strobes))
                addr_err_tot <= addr_err_tot + 1;
            if (count_for_bram_en) begin
                strobes_tot <= strobes_tot + 1;
                pkt_strobes <= pkt_strobes + 1;
            end
            if (prev_du && !data_user) du_falls_tot <= du_falls_tot + 1;
            if (pkt_done) begin
                last_done <= cyc;
                done_vld  <= 1'b1;
            end
            if (frame_done)    fdone_tot  <= fdone_tot + 1;
            if (cfg_err)       cfgerr_tot <= cfgerr_tot + 1;
            if (frame_overrun) ovr_tot    <= ovr_tot + 1;
            if (txid == 8'd0)  txid0_tot  <= txid0_tot + 1;
            prev_du  <= data_user;
            prev_req <= pkt_req;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk125MHz);
        #1;
    endtask

    task automatic start_frame(input int n, input int r, input int len);
        cfg_num_segments = 16'(n);
        cfg_redundancy   = 8'(r);
        cfg_payload_len  = LW'(len);
        frame_start      = 1'b1;
        tick();
        frame_start      = 1'b0;
    endtask

    // Framer model: accept one request, read len bytes, then report completion.
    task automatic serve_packet(input int len, input bit toggle, input bit done_last,
                                input bit inject, output bit ok);
        int t;
        int n;
        int i;
        ok = 1'b1;
        t = 0;
        while (!pkt_req && t < 200) begin
            tick();
            t++;
        end
        if (!pkt_req) begin
            ok = 1'b0;
            return;
        end
        pkt_ack = 1'b1;
        tick();
        pkt_ack = 1'b0;
        n = 0;
        i = 0;
        while (n < len && i < 400) begin
            payload_rd  = toggle ? (i % 3 == 0) : 1'b1;
            pkt_done    = done_last && payload_rd && (n == len - 1);
            frame_start = inject && (i == 1);
            if (payload_rd) n++;
            i++;
            tick();
        end
        payload_rd  = 1'b0;
        pkt_done    = 1'b0;
        frame_start = 1'b0;
        if (n < len) ok = 1'b0;
        if (!done_last) begin
            tick();
            pkt_done = 1'b1;
            tick();
            pkt_done = 1'b0;
        end
    endtask

    task automatic wait_idle(output bit ok);
        int t;
        t = 0;
        while (busy && t < 100) begin
            tick();
            t++;
        end
        ok = !busy;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        tick();
        tick();
        n_checks++; if (pkt_req !== 1'b0)     begin n_errors++; $display("FAIL reset_pkt_req: got %0b expected 0", pkt_req); end
        n_checks++; if (txid !== 8'd1)        begin n_errors++; $display("FAIL reset_txid: got %0d expected 1", txid); end
        n_checks++; if (segment_num !== 16'd0) begin n_errors++; $display("FAIL reset_seg: got %0d expected 0", segment_num); end
        n_checks++; if (busy !== 1'b0)        begin n_errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_checks++; if (data_user !== 1'b0)   begin n_errors++; $display("FAIL reset_data_user: got %0b expected 0", data_user); end
        n_checks++; if (count_for_bram !== '0) begin n_errors++; $display("FAIL reset_addr: got %0d expected 0", count_for_bram); end
        n_checks++; if (frame_done !== 1'b0)  begin n_errors++; $display("FAIL reset_frame_done: got %0b expected 0", frame_done); end
        n_checks++; if (cfg_err !== 1'b0)     begin n_errors++; $display("FAIL reset_cfg_err: got %0b expected 0", cfg_err); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_frame();
        int b_log, b_str, b_addr, b_fall, b_fd;
        bit ok;
        b_log = log_txid.size(); b_str = strobes_tot; b_addr = addr_err_tot;
        b_fall = du_falls_tot; b_fd = fdone_tot;
        start_frame(3, 2, 4);
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL basic_busy: got %0b expected 1", busy); end
        for (int p = 0; p < 6; p++) begin
            serve_packet(4, 1'b0, 1'b0, 1'b0, ok);
            n_checks++; if (!ok) begin n_errors++; $display("FAIL basic_serve%0d: got timeout expected packet", p); end
        end
        wait_idle(ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL basic_idle: got busy expected idle"); end
        for (int p = 0; p < 6; p++) begin
            n_checks++;
            if (b_log + p >= log_txid.size()) begin
                n_errors++; $display("FAIL basic_pkt%0d: got missing expected (%0d,%0d)", p, p / 3 + 1, p % 3);
            end else if (log_txid[b_log + p] !== p / 3 + 1 || log_seg[b_log + p] !== p % 3) begin
                n_errors++; $display("FAIL basic_pkt%0d: got (%0d,%0d) expected (%0d,%0d)", p,
                                     log_txid[b_log + p], log_seg[b_log + p], p / 3 + 1, p % 3);
            end
        end
        for (int p = 1; p < 6; p++) begin
            if (b_log + p < log_gap.size()) begin
                n_checks++;
                if (log_gap[b_log + p] < 12) begin n_errors++; $display("FAIL basic_gap%0d: got %0d expected >=12", p, log_gap[b_log + p]); end
            end
        end
        n_checks++; if (strobes_tot - b_str !== 24) begin n_errors++; $display("FAIL basic_strobes: got %0d expected 24", strobes_tot - b_str); end
        n_checks++; if (addr_err_tot - b_addr !== 0) begin n_errors++; $display("FAIL basic_addr: got %0d bad expected 0", addr_err_tot - b_addr); end
        n_checks++; if (du_falls_tot - b_fall !== 6) begin n_errors++; $display("FAIL basic_du_falls: got %0d expected 6", du_falls_tot - b_fall); end
        n_checks++; if (fdone_tot - b_fd !== 1) begin n_errors++; $display("FAIL basic_frame_done: got %0d expected 1", fdone_tot - b_fd); end
        n_checks++; if (txid !== 8'd1) begin n_errors++; $display("FAIL basic_txid_end: got %0d expected 1", txid); end
    endtask

    task automatic test_payload_stall();
        int b_str, b_addr, b_fall, b_fd;
        bit ok;
        b_str = strobes_tot; b_addr = addr_err_tot; b_fall = du_falls_tot; b_fd = fdone_tot;
        start_frame(1, 1, 5);
        serve_packet(5, 1'b1, 1'b0, 1'b0, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL stall_serve: got timeout expected packet"); end
        wait_idle(ok);
        n_checks++; if (strobes_tot - b_str !== 5) begin n_errors++; $display("FAIL stall_strobes: got %0d expected 5", strobes_tot - b_str); end
        n_checks++; if (addr_err_tot - b_addr !== 0) begin n_errors++; $display("FAIL stall_addr_hold: got %0d bad expected 0", addr_err_tot - b_addr); end
        n_checks++; if (du_falls_tot - b_fall !== 1) begin n_errors++; $display("FAIL stall_du_falls: got %0d expected 1", du_falls_tot - b_fall); end
        n_checks++; if (fdone_tot - b_fd !== 1) begin n_errors++; $display("FAIL stall_frame_done: got %0d expected 1", fdone_tot - b_fd); end
    endtask

    task automatic test_cfg_err();
        int b_err, b_req;
        int bad_n[4] = '{0, 151, 2, 2};
        int bad_r[4] = '{1, 1, 0, 1};
        int bad_l[4] = '{4, 4, 4, 0};
        b_err = cfgerr_tot; b_req = req_tot;
        for (int k = 0; k < 4; k++) begin
            start_frame(bad_n[k], bad_r[k], bad_l[k]);
            n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL cfg_busy%0d: got %0b expected 0", k, busy); end
            tick();
        end
        tick();
        n_checks++; if (cfgerr_tot - b_err !== 4) begin n_errors++; $display("FAIL cfg_err_pulses: got %0d expected 4", cfgerr_tot - b_err); end
        n_checks++; if (req_tot - b_req !== 0) begin n_errors++; $display("FAIL cfg_no_req: got %0d expected 0", req_tot - b_req); end
    endtask

    task automatic test_overrun();
        int b_log, b_str, b_fd, b_ovr, b_req, b_err, t;
        bit ok;
        b_log = log_txid.size(); b_str = strobes_tot; b_fd = fdone_tot;
        b_ovr = ovr_tot; b_req = req_tot; b_err = cfgerr_tot;
        start_frame(2, 1, 3);
        serve_packet(3, 1'b0, 1'b0, 1'b0, ok);
        serve_packet(3, 1'b0, 1'b0, 1'b1, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL ovr_serve: got timeout expected packet"); end
        t = 0;
        while (!frame_done && t < 40) begin tick(); t++; end
        n_checks++; if (frame_done !== 1'b1) begin n_errors++; $display("FAIL ovr_done_wait: got %0b expected 1", frame_done); end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        tick();
        n_checks++; if (ovr_tot - b_ovr !== 2) begin n_errors++; $display("FAIL ovr_pulses: got %0d expected 2", ovr_tot - b_ovr); end
        n_checks++; if (fdone_tot - b_fd !== 1) begin n_errors++; $display("FAIL ovr_frame_done: got %0d expected 1", fdone_tot - b_fd); end
        n_checks++; if (req_tot - b_req !== 2) begin n_errors++; $display("FAIL ovr_req_count: got %0d expected 2", req_tot - b_req); end
        n_checks++; if (strobes_tot - b_str !== 6) begin n_errors++; $display("FAIL ovr_strobes: got %0d expected 6", strobes_tot - b_str); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL ovr_busy: got %0b expected 0", busy); end
        n_checks++; if (cfgerr_tot - b_err !== 0) begin n_errors++; $display("FAIL ovr_cfg_err: got %0d expected 0", cfgerr_tot - b_err); end
        n_checks++;
        if (log_txid.size() < b_log + 2) begin
            n_errors++; $display("FAIL ovr_seq: got %0d packets expected 2", log_txid.size() - b_log);
        end else if (log_txid[b_log] !== 1 || log_seg[b_log] !== 0 || log_txid[b_log + 1] !== 1 || log_seg[b_log + 1] !== 1) begin
            n_errors++; $display("FAIL ovr_seq: got (%0d,%0d),(%0d,%0d) expected (1,0),(1,1)",
                                 log_txid[b_log], log_seg[b_log], log_txid[b_log + 1], log_seg[b_log + 1]);
        end
    endtask

    task automatic test_reset_mid_packet();
        int b_log, b_str, b_addr, b_fd, t;
        bit ok;
        start_frame(2, 1, 4);
        t = 0;
        while (!pkt_req && t < 50) begin tick(); t++; end
        pkt_ack = 1'b1;
        tick();
        pkt_ack = 1'b0;
        payload_rd = 1'b1;
        tick();
        tick();
        n_checks++; if (count_for_bram !== LW'(2)) begin n_errors++; $display("FAIL rstmid_pre_addr: got %0d expected 2", count_for_bram); end
        rst = 1'b1;
        #1;
        n_checks++; if (data_user !== 1'b0 || count_for_bram_en !== 1'b0) begin n_errors++; $display("FAIL rstmid_du_en: got %0b%0b expected 00", data_user, count_for_bram_en); end
        n_checks++; if (count_for_bram !== '0 || count_for_bram_b !== '0) begin n_errors++; $display("FAIL rstmid_addr: got %0d/%0d expected 0/0", count_for_bram, count_for_bram_b); end
        n_checks++; if (txid !== 8'd1 || segment_num !== 16'd0) begin n_errors++; $display("FAIL rstmid_ids: got (%0d,%0d) expected (1,0)", txid, segment_num); end
        n_checks++; if (busy !== 1'b0 || pkt_req !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy_req: got %0b%0b expected 00", busy, pkt_req); end
        b_fd = fdone_tot;
        tick();
        payload_rd = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        n_checks++; if (fdone_tot - b_fd !== 0) begin n_errors++; $display("FAIL rstmid_no_done: got %0d expected 0", fdone_tot - b_fd); end
        b_log = log_txid.size(); b_str = strobes_tot; b_addr = addr_err_tot;
        start_frame(1, 1, 2);
        serve_packet(2, 1'b0, 1'b0, 1'b0, ok);
        wait_idle(ok);
        n_checks++;
        if (log_txid.size() != b_log + 1) begin
            n_errors++; $display("FAIL rstmid_restart: got %0d packets expected 1", log_txid.size() - b_log);
        end else if (log_txid[b_log] !== 1 || log_seg[b_log] !== 0) begin
            n_errors++; $display("FAIL rstmid_restart: got (%0d,%0d) expected (1,0)", log_txid[b_log], log_seg[b_log]);
        end
        n_checks++; if (strobes_tot - b_str !== 2 || addr_err_tot - b_addr !== 0) begin n_errors++; $display("FAIL rstmid_bytes: got %0d strobes %0d bad expected 2/0", strobes_tot - b_str, addr_err_tot - b_addr); end
        n_checks++; if (fdone_tot - b_fd !== 1) begin n_errors++; $display("FAIL rstmid_frame_done: got %0d expected 1", fdone_tot - b_fd); end
    endtask

    task automatic test_back_to_back_r255();
        int b_log, b_fd, b_z, served, seq_bad, min_gap;
        bit ok;
        b_log = log_txid.size(); b_fd = fdone_tot; b_z = txid0_tot;
        served = 0;
        start_frame(1, 255, 2);
        for (int p = 0; p < 255; p++) begin
            serve_packet(2, 1'b0, 1'b1, 1'b0, ok);
            if (!ok) break;
            served++;
        end
        wait_idle(ok);
        n_checks++; if (served !== 255) begin n_errors++; $display("FAIL r255_served: got %0d expected 255", served); end
        seq_bad = 0;
        min_gap = 9999;
        for (int p = 0; p < 255; p++) begin
            if (b_log + p >= log_txid.size()) begin
                seq_bad++;
            end else begin
                if (log_txid[b_log + p] != p + 1 || log_seg[b_log + p] != 0) seq_bad++;
                if (p > 0 && log_gap[b_log + p] < min_gap) min_gap = log_gap[b_log + p];
            end
        end
        n_checks++; if (seq_bad !== 0) begin n_errors++; $display("FAIL r255_sequence: got %0d bad entries expected 0", seq_bad); end
        n_checks++; if (min_gap < 12) begin n_errors++; $display("FAIL r255_gap: got %0d expected >=12", min_gap); end
        n_checks++; if (txid0_tot - b_z !== 0) begin n_errors++; $display("FAIL r255_txid_wrap: got %0d zero cycles expected 0", txid0_tot - b_z); end
        n_checks++; if (fdone_tot - b_fd !== 1) begin n_errors++; $display("FAIL r255_frame_done: got %0d expected 1", fdone_tot - b_fd); end
        n_checks++; if (log_txid.size() - b_log !== 255) begin n_errors++; $display("FAIL r255_pkt_count: got %0d expected 255", log_txid.size() - b_log); end
        n_checks++; if (txid !== 8'd1 || busy !== 1'b0) begin n_errors++; $display("FAIL r255_end_state: got txid %0d busy %0b expected 1/0", txid, busy); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_payload_stall();
        test_cfg_err();
        test_overrun();
        test_reset_mid_packet();
        test_back_to_back_r255();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "time limit");
    end

endmodule
